// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

  localparam int          INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request, a single-entry output
// register for decode, and redirect/flush handling that steers the PC.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter int                INSTR_W = 32,
  parameter logic [INSTR_W-1:0] NOP    = INSTR_W'(NOP_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  next,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_fault
);

  fetch_state_e       state_reg, state_next;
  logic [ADDR_W-1:0]  req_pc_reg, req_pc_next;
  logic               valid_reg, valid_next;
  logic               fault_reg, fault_next;
  logic [INSTR_W-1:0] instr_reg, instr_next;
  logic [ADDR_W-1:0]  ipc_reg, ipc_next;

  logic misaligned;
  logic accept;

  assign misaligned     = (pc[1:0] != 2'b00);
  assign imem_req_valid = (state_reg == REQ) && !misaligned;
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign if_valid = valid_reg;
  assign if_fault = fault_reg;
  assign if_instr = instr_reg;
  assign if_pc    = ipc_reg;

  always_comb begin
    state_next  = state_reg;
    req_pc_next = req_pc_reg;
    valid_next  = valid_reg;
    fault_next  = fault_reg;
    instr_next  = instr_reg;
    ipc_next    = ipc_reg;
    next        = pc;

    unique case (state_reg)
      IDLE: state_next = REQ;
      REQ: begin
        if (misaligned) begin
          instr_next = NOP;
          ipc_next   = pc;
          fault_next = 1'b1;
          valid_next = 1'b1;
          state_next = HOLD;
        end else if (accept) begin
          req_pc_next = pc;
          next        = pc + ADDR_W'(INSTR_BYTES);
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          instr_next = imem_rsp_data;
          ipc_next   = req_pc_reg;
          fault_next = 1'b0;
          valid_next = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: begin
        // A fault entry stays presented after acceptance until a redirect.
        if (valid_reg && if_ready && !fault_reg) begin
          valid_next = 1'b0;
          state_next = REQ;
        end
      end
      DROP: begin
        if (imem_rsp_valid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase

    // Redirect overrides everything above; DROP only if a request is still in flight.
    if (redirect && state_reg != IDLE) begin
      next       = redirect_target;
      valid_next = 1'b0;
      fault_next = 1'b0;
      if ((state_reg == WAIT && !imem_rsp_valid) ||
          (state_reg == DROP && !imem_rsp_valid) ||
          (state_reg == REQ && accept))
        state_next = DROP;
      else
        state_next = REQ;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      req_pc_reg <= '0;
      valid_reg  <= 1'b0;
      fault_reg  <= 1'b0;
      instr_reg  <= '0;
      ipc_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      req_pc_reg <= req_pc_next;
      valid_reg  <= valid_next;
      fault_reg  <= fault_next;
      instr_reg  <= instr_next;
      ipc_reg    <= ipc_next;
    end
  end

endmodule
